// File: rtl/fifo_write_ctrl.sv
// Write-side controller for a small packet FIFO: parses header bytes, writes packets
// into entry-organised packet memory, and tracks stored-packet occupancy.
module fifo_write_ctrl #(
    parameter int DEPTH     = 3,
    parameter int WIDTH     = 11,
    parameter int UWIDTH    = 8,
    parameter int PTR_SZ    = 2,
    parameter int PTR_IN_SZ = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [UWIDTH-1:0]    in_data,
    output logic                 in_ready,
    // "release" is a reserved word, so the downstream consume pulse is pkt_release
    input  logic                 pkt_release,
    output logic                 write_en,
    output logic [PTR_SZ-1:0]    waddr,
    output logic [PTR_IN_SZ-1:0] waddr_in,
    output logic [UWIDTH-1:0]    wdata,
    output logic                 pkt_done,
    output logic [PTR_SZ-1:0]    pkt_entry,
    output logic [1:0]           pkt_dest,
    output logic [PTR_IN_SZ-1:0] pkt_len,
    output logic [PTR_SZ-1:0]    count,
    output logic                 full,
    output logic                 empty,
    output logic [PTR_SZ-1:0]    head_ptr,
    output logic                 err_hdr
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        DROP    = 2'd2
    } state_t;

    localparam logic [PTR_SZ-1:0]    LAST_PTR = PTR_SZ'(DEPTH - 1);
    localparam logic [PTR_SZ-1:0]    DEPTH_C  = PTR_SZ'(DEPTH);
    localparam logic [PTR_IN_SZ-1:0] MAX_LEN  = PTR_IN_SZ'(WIDTH - 1);

    function automatic logic [PTR_SZ-1:0] ptr_inc(input logic [PTR_SZ-1:0] p);
        return (p == LAST_PTR) ? {PTR_SZ{1'b0}} : p + 1'b1;
    endfunction

    state_t                state_q, state_d;
    logic [PTR_SZ-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_SZ-1:0]     head_ptr_q, head_ptr_d;
    logic [PTR_SZ-1:0]     count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  pkt_done_q, pkt_done_d;
    logic [PTR_SZ-1:0]     pkt_entry_q, pkt_entry_d;
    logic [1:0]            pkt_dest_q, pkt_dest_d;
    logic [PTR_IN_SZ-1:0]  pkt_len_q, pkt_len_d;
    logic                  err_hdr_q, err_hdr_d;
    logic [PTR_IN_SZ-1:0]  len_q, len_d;
    logic [PTR_IN_SZ-1:0]  idx_q, idx_d;
    logic [1:0]            dest_q, dest_d;

    logic                  accept;
    logic                  commit;
    logic                  rel_ok;
    logic [1:0]            commit_dest;
    logic [PTR_IN_SZ-1:0]  commit_len;
    logic [1:0]            hdr_dest;
    logic [3:0]            hdr_len;
    logic                  hdr_ok;

    assign hdr_dest = in_data[7:6];
    assign hdr_len  = in_data[3:0];
    assign hdr_ok   = (hdr_dest != 2'd0) && (hdr_len <= MAX_LEN);
    assign accept   = in_valid && in_ready;
    assign rel_ok   = pkt_release && (count_q != {PTR_SZ{1'b0}});

    // State and bookkeeping registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            head_ptr_q  <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            pkt_done_q  <= 1'b0;
            pkt_entry_q <= '0;
            pkt_dest_q  <= 2'd0;
            pkt_len_q   <= '0;
            err_hdr_q   <= 1'b0;
            len_q       <= '0;
            idx_q       <= '0;
            dest_q      <= 2'd0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            head_ptr_q  <= head_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            pkt_done_q  <= pkt_done_d;
            pkt_entry_q <= pkt_entry_d;
            pkt_dest_q  <= pkt_dest_d;
            pkt_len_q   <= pkt_len_d;
            err_hdr_q   <= err_hdr_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            dest_q      <= dest_d;
        end
    end

    // Next-state logic: header parsing, payload sequencing and commit detection
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        dest_d      = dest_q;
        commit      = 1'b0;
        commit_dest = dest_q;
        commit_len  = len_q;
        err_hdr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!accept) begin
                    state_d = IDLE;
                end else if (hdr_len > MAX_LEN) begin
                    err_hdr_d = 1'b1;
                end else if (hdr_dest == 2'd0) begin
                    err_hdr_d = 1'b1;
                    len_d     = hdr_len;
                    idx_d     = {{(PTR_IN_SZ-1){1'b0}}, 1'b1};
                    state_d   = (hdr_len != 4'd0) ? DROP : IDLE;
                end else if (hdr_len == 4'd0) begin
                    commit      = 1'b1;
                    commit_dest = hdr_dest;
                    commit_len  = '0;
                end else begin
                    state_d = PAYLOAD;
                    len_d   = hdr_len;
                    dest_d  = hdr_dest;
                    idx_d   = {{(PTR_IN_SZ-1){1'b0}}, 1'b1};
                end
            end
            PAYLOAD, DROP: begin
                if (!accept) begin
                    state_d = state_q;
                end else if (idx_q == len_q) begin
                    state_d = IDLE;
                    commit  = (state_q == PAYLOAD);
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Occupancy, pointers and registered commit report
    always_comb begin
        wr_ptr_d    = commit ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        head_ptr_d  = rel_ok ? ptr_inc(head_ptr_q) : head_ptr_q;
        case ({commit, rel_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d      = (count_d == DEPTH_C);
        empty_d     = (count_d == {PTR_SZ{1'b0}});
        pkt_done_d  = commit;
        if (commit) begin
            pkt_entry_d = wr_ptr_q;
            pkt_dest_d  = commit_dest;
            pkt_len_d   = commit_len;
        end else begin
            pkt_entry_d = pkt_entry_q;
            pkt_dest_d  = pkt_dest_q;
            pkt_len_d   = pkt_len_q;
        end
    end

    // Input handshake; full is the registered value, so a same-cycle release does not help
    always_comb begin
        case (state_q)
            IDLE:          in_ready = !rst && !full_q;
            PAYLOAD, DROP: in_ready = !rst;
            default:       in_ready = 1'b0;
        endcase
    end

    // Packet-memory write port, combinational with the accepted byte
    always_comb begin
        waddr    = wr_ptr_q;
        wdata    = in_data;
        case (state_q)
            IDLE: begin
                write_en = accept && hdr_ok;
                waddr_in = '0;
            end
            PAYLOAD: begin
                write_en = accept;
                waddr_in = idx_q;
            end
            default: begin
                write_en = 1'b0;
                waddr_in = '0;
            end
        endcase
    end

    assign pkt_done  = pkt_done_q;
    assign pkt_entry = pkt_entry_q;
    assign pkt_dest  = pkt_dest_q;
    assign pkt_len   = pkt_len_q;
    assign count     = count_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign head_ptr  = head_ptr_q;
    assign err_hdr   = err_hdr_q;

endmodule
